// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback stream and an out-of-band multi-cycle unit (mul/div).
// Multi-cycle results wait in a small FIFO and are written in idle writeback
// slots. A head that starves gets a forced one-cycle pipeline stall.
// Younger pipeline writes squash queued results to the same rd, which keeps
// write-after-write ordering intact.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   wb_regwrt_i          pipeline WB write request
//   wb_alu_to_reg_i      1 = ALU result, 0 = memory result
//   wb_alu_res_i         pipeline ALU result
//   wb_mem_res_i         pipeline memory data
//   wb_rd_i              pipeline destination register
//   mc_valid_i           multi-cycle result offered
//   mc_ready_o           FIFO can accept (combinational)
//   mc_rd_i, mc_data_i   multi-cycle destination / result
//   rf_we_o              register-file write enable (registered)
//   rf_waddr_o           register-file write address (registered)
//   rf_wdata_o           register-file write data (registered)
//   stall_o              freeze IF..WB pipeline registers (registered)
//   fifo_count_o         occupied FIFO slots, valid or squashed
module wb_port_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_regwrt_i,
  input  logic                     wb_alu_to_reg_i,
  input  logic [31:0]              wb_alu_res_i,
  input  logic [31:0]              wb_mem_res_i,
  input  logic [5:0]               wb_rd_i,
  input  logic                     mc_valid_i,
  output logic                     mc_ready_o,
  input  logic [5:0]               mc_rd_i,
  input  logic [31:0]              mc_data_i,
  output logic                     rf_we_o,
  output logic [5:0]               rf_waddr_o,
  output logic [31:0]              rf_wdata_o,
  output logic                     stall_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = 4;

  // FIFO storage and bookkeeping
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [5:0]       rd_q  [DEPTH];
  logic [31:0]      dat_q [DEPTH];
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    wait_q, wait_d;

  // Registered outputs
  logic             we_q, we_d;
  logic [5:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             stall_q, stall_d;

  // Per-cycle decisions
  logic             fifo_empty;
  logic             head_vld;
  logic             push;
  logic             pipe_wr;
  logic             head_wr;
  logic             pop;
  logic             head_squash;
  logic [WW-1:0]    wait_inc;

  assign mc_ready_o   = rst_n & (cnt_q < CW'(DEPTH));
  assign rf_we_o      = we_q;
  assign rf_waddr_o   = waddr_q;
  assign rf_wdata_o   = wdata_q;
  assign stall_o      = stall_q;
  assign fifo_count_o = cnt_q;

  // Grant, squash, FIFO and starvation next-state
  always_comb begin
    vld_d    = vld_q;
    rp_d     = rp_q;
    wp_d     = wp_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    stall_d  = 1'b0;

    fifo_empty  = (cnt_q == CW'(0));
    head_vld    = !fifo_empty && vld_q[rp_q];
    push        = mc_valid_i && mc_ready_o;
    // During a stall the WB buffer is frozen; its request is re-presented later
    pipe_wr     = !stall_q && wb_regwrt_i;
    head_wr     = head_vld && (stall_q || !wb_regwrt_i);
    // Squashed heads are discarded whether or not the pipeline writes
    pop         = !fifo_empty && (head_wr || !vld_q[rp_q]);
    head_squash = pipe_wr && (rd_q[rp_q] == wb_rd_i);
    wait_inc    = (wait_q == WW'(15)) ? wait_q : wait_q + WW'(1);

    // Port grant
    if (head_wr) begin
      we_d    = 1'b1;
      waddr_d = rd_q[rp_q];
      wdata_d = dat_q[rp_q];
    end else if (pipe_wr) begin
      we_d    = 1'b1;
      waddr_d = wb_rd_i;
      wdata_d = wb_alu_to_reg_i ? wb_alu_res_i : wb_mem_res_i;
    end

    // WAW squash of every queued entry the younger pipeline write supersedes
    if (pipe_wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_q[i] == wb_rd_i) vld_d[i] = 1'b0;
      end
    end

    // Push lands in a free slot; it is squashed too if it targets the same rd
    if (push) begin
      vld_d[wp_q] = !(pipe_wr && (mc_rd_i == wb_rd_i));
      wp_d        = wp_q + AW'(1);
    end

    if (pop) rp_d = rp_q + AW'(1);

    cnt_d = cnt_q + CW'(push) - CW'(pop);

    // Starvation tracking: only a valid head left unserved accumulates wait
    if (pop || fifo_empty) begin
      wait_d = '0;
    end else if (head_vld) begin
      wait_d = wait_inc;
      // Skip the stall if this cycle's pipeline write just squashed the head
      if (!stall_q && !head_squash && (wait_inc >= WW'(STARVE_LIMIT))) begin
        stall_d = 1'b1;
      end
    end else begin
      wait_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      rp_q    <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      stall_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      stall_q <= stall_d;
      if (push) begin
        rd_q[wp_q]  <= mc_rd_i;
        dat_q[wp_q] <= mc_data_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a write-order scoreboard.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_regwrt_i;
  logic        wb_alu_to_reg_i;
  logic [31:0] wb_alu_res_i;
  logic [31:0] wb_mem_res_i;
  logic [5:0]  wb_rd_i;
  logic        mc_valid_i;
  logic        mc_ready_o;
  logic [5:0]  mc_rd_i;
  logic [31:0] mc_data_i;
  logic        rf_we_o;
  logic [5:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        stall_o;
  logic [1:0]  fifo_count_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb_regwrt_i     (wb_regwrt_i),
    .wb_alu_to_reg_i (wb_alu_to_reg_i),
    .wb_alu_res_i    (wb_alu_res_i),
    .wb_mem_res_i    (wb_mem_res_i),
    .wb_rd_i         (wb_rd_i),
    .mc_valid_i      (mc_valid_i),
    .mc_ready_o      (mc_ready_o),
    .mc_rd_i         (mc_rd_i),
    .mc_data_i       (mc_data_i),
    .rf_we_o         (rf_we_o),
    .rf_waddr_o      (rf_waddr_o),
    .rf_wdata_o      (rf_wdata_o),
    .stall_o         (stall_o),
    .fifo_count_o    (fifo_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void expect_wr(input logic [5:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endfunction

  // Advance one cycle, sample after the edge, and score any rf write
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (rf_we_o === 1'b1) begin
      chk("sb_expected_write", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("sb_waddr", 32'(rf_waddr_o), 32'(w.addr));
        chk("sb_wdata", rf_wdata_o, w.data);
      end
    end
  endtask

  task automatic pipe(input logic en, input logic [5:0] rd, input logic [31:0] alu);
    wb_regwrt_i     = en;
    wb_alu_to_reg_i = 1'b1;
    wb_alu_res_i    = alu;
    wb_mem_res_i    = ~alu;
    wb_rd_i         = rd;
  endtask

  task automatic mc(input logic en, input logic [5:0] rd, input logic [31:0] d);
    mc_valid_i = en;
    mc_rd_i    = rd;
    mc_data_i  = d;
  endtask

  initial begin
    // Reset with busy inputs
    rst_n = 1'b0;
    pipe(1'b1, 6'd2, 32'h1111_2222);
    mc(1'b1, 6'd3, 32'h3333_4444);
    tick(); tick(); tick();
    chk("rst_we", 32'(rf_we_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_ready", 32'(mc_ready_o), 32'd0);
    chk("rst_count", 32'(fifo_count_o), 32'd0);
    chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);

    rst_n = 1'b1;
    pipe(1'b0, 6'd0, 32'd0);
    mc(1'b0, 6'd0, 32'd0);
    tick();
    chk("ready_after_rst", 32'(mc_ready_o), 32'd1);

    // Pipeline only, memory result selected
    wb_regwrt_i     = 1'b1;
    wb_alu_to_reg_i = 1'b0;
    wb_mem_res_i    = 32'hDEAD_BEEF;
    wb_alu_res_i    = 32'h0BAD_F00D;
    wb_rd_i         = 6'd5;
    expect_wr(6'd5, 32'hDEAD_BEEF);
    tick();
    chk("pipe_mem_we", 32'(rf_we_o), 32'd1);
    // Pipeline only, ALU result selected
    pipe(1'b1, 6'd9, 32'hA5A5_0001);
    expect_wr(6'd9, 32'hA5A5_0001);
    tick();
    pipe(1'b0, 6'd0, 32'd0);
    tick();
    chk("idle_we", 32'(rf_we_o), 32'd0);
    chk("idle_hold_addr", 32'(rf_waddr_o), 32'd9);

    // Idle drain
    mc(1'b1, 6'd7, 32'h0000_1234);
    expect_wr(6'd7, 32'h0000_1234);
    tick();
    chk("drain_count1", 32'(fifo_count_o), 32'd1);
    chk("drain_we0", 32'(rf_we_o), 32'd0);
    mc(1'b0, 6'd0, 32'd0);
    tick();
    chk("drain_we1", 32'(rf_we_o), 32'd1);
    chk("drain_count0", 32'(fifo_count_o), 32'd0);

    // Starvation: four blocked cycles, one stall cycle, then the held write
    mc(1'b1, 6'd10, 32'h00C0_FFEE);
    for (int i = 1; i <= 5; i++) begin
      pipe(1'b1, 6'd1, 32'h100 + 32'(i));
      expect_wr(6'd1, 32'h100 + 32'(i));
      tick();
      mc(1'b0, 6'd0, 32'd0);
      chk("starve_stall", 32'(stall_o), 32'(i == 5));
    end
    pipe(1'b1, 6'd1, 32'h106);
    expect_wr(6'd10, 32'h00C0_FFEE);
    tick();
    chk("starve_stall_drop", 32'(stall_o), 32'd0);
    chk("starve_count", 32'(fifo_count_o), 32'd0);
    expect_wr(6'd1, 32'h106);
    tick();
    pipe(1'b0, 6'd0, 32'd0);
    tick();
    chk("starve_idle", 32'(rf_we_o), 32'd0);

    // Squash of a queued entry by a younger pipeline write
    mc(1'b1, 6'd3, 32'h0000_3333);
    tick();
    mc(1'b0, 6'd0, 32'd0);
    pipe(1'b1, 6'd3, 32'h0000_3AAA);
    expect_wr(6'd3, 32'h0000_3AAA);
    tick();
    chk("squash_count1", 32'(fifo_count_o), 32'd1);
    pipe(1'b0, 6'd0, 32'd0);
    tick();
    chk("squash_no_write", 32'(rf_we_o), 32'd0);
    chk("squash_count0", 32'(fifo_count_o), 32'd0);

    // Squash of a result accepted in the same cycle
    mc(1'b1, 6'd4, 32'h0000_4444);
    pipe(1'b1, 6'd4, 32'h0000_4AAA);
    expect_wr(6'd4, 32'h0000_4AAA);
    tick();
    chk("same_squash_count1", 32'(fifo_count_o), 32'd1);
    mc(1'b0, 6'd0, 32'd0);
    pipe(1'b0, 6'd0, 32'd0);
    tick();
    chk("same_squash_no_write", 32'(rf_we_o), 32'd0);
    chk("same_squash_count0", 32'(fifo_count_o), 32'd0);

    // Full FIFO with the pipeline busy
    mc(1'b1, 6'd21, 32'hA000_0021);
    for (int i = 1; i <= 5; i++) begin
      pipe(1'b1, 6'd20, 32'h200 + 32'(i));
      expect_wr(6'd20, 32'h200 + 32'(i));
      tick();
      if (i == 1) begin
        chk("full_ready1", 32'(mc_ready_o), 32'd1);
        mc(1'b1, 6'd22, 32'hB000_0022);
      end else begin
        chk("full_ready0", 32'(mc_ready_o), 32'd0);
        chk("full_count2", 32'(fifo_count_o), 32'd2);
        mc(1'b1, 6'd23, 32'hC000_0023);
      end
    end
    chk("full_stall", 32'(stall_o), 32'd1);
    pipe(1'b1, 6'd20, 32'h206);
    expect_wr(6'd21, 32'hA000_0021);
    tick();
    chk("full_ready_rise", 32'(mc_ready_o), 32'd1);
    chk("full_count1", 32'(fifo_count_o), 32'd1);
    expect_wr(6'd20, 32'h206);
    tick();
    chk("full_count_c", 32'(fifo_count_o), 32'd2);
    mc(1'b0, 6'd0, 32'd0);
    pipe(1'b0, 6'd0, 32'd0);
    expect_wr(6'd22, 32'hB000_0022);
    tick();
    expect_wr(6'd23, 32'hC000_0023);
    tick();
    chk("full_count0", 32'(fifo_count_o), 32'd0);

    // Reset mid-operation discards queued results
    mc(1'b1, 6'd30, 32'hE000_0030);
    pipe(1'b1, 6'd31, 32'h0000_0031);
    expect_wr(6'd31, 32'h0000_0031);
    tick();
    chk("midrst_count1", 32'(fifo_count_o), 32'd1);
    mc(1'b0, 6'd0, 32'd0);
    pipe(1'b0, 6'd0, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("midrst_count0", 32'(fifo_count_o), 32'd0);
    chk("midrst_we", 32'(rf_we_o), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("midrst_no_drain", 32'(rf_we_o), 32'd0);

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stream and a multi-cycle execution unit (divider/multiplier) that returns results out of band. It sits after the EX/MEM-to-WB buffer and selects the writeback data (ALU result or memory read data). Multi-cycle results are queued in a small FIFO, drained into idle writeback slots, and forced through with a one-cycle pipeline stall when starved. Write-after-write ordering is preserved by squashing queued results superseded by younger pipeline writes.

## Interface
- DEPTH, 2: multi-cycle result FIFO entries (power of two, 2..8)
- STARVE_LIMIT, 4: cycles a valid FIFO head may wait before a forced stall (1..15)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset; sampled only on clk rising edge
- wb_regwrt_i  in  1  pipeline WB wants a register write (RegWrt from WB buffer)
- wb_alu_to_reg_i  in  1  1 = write ALU result, 0 = write memory result
- wb_alu_res_i  in  32  pipeline ALU result
- wb_mem_res_i  in  32  pipeline memory read data
- wb_rd_i  in  6  pipeline destination register
- mc_valid_i  in  1  multi-cycle unit presents a result
- mc_ready_o  out  1  FIFO can accept; transfer when mc_valid_i & mc_ready_o
- mc_rd_i  in  6  multi-cycle destination register
- mc_data_i  in  32  multi-cycle result
- rf_we_o  out  1  register-file write enable (registered)
- rf_waddr_o  out  6  register-file write address (registered)
- rf_wdata_o  out  32  register-file write data (registered)
- stall_o  out  1  freeze IF..WB pipeline registers this cycle (registered)
- fifo_count_o  out  $clog2(DEPTH)+1  occupied FIFO slots, valid or squashed

## Operation
- Reset (rst_n low at edge): rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, stall_o=0, FIFO empty, count=0, wait counter=0. mc_ready_o=0 while rst_n low; all inputs ignored. Reset mid-operation discards all queued results.
- mc_ready_o = rst_n & (count < DEPTH), combinational. Accepted result appended at tail with valid=1.
- Per-cycle grant (one write maximum):
  - stall_o=1 this cycle: pipeline inputs ignored (WB buffer is frozen and re-presents them next cycle); valid FIFO head written and popped.
  - else wb_regwrt_i=1: pipeline wins; data = wb_alu_to_reg_i ? wb_alu_res_i : wb_mem_res_i, address = wb_rd_i.
  - else valid FIFO head exists: head written and popped.
  - else rf_we_o=0 next cycle; address/data hold previous values.
- Squash (WAW): on a granted pipeline write to rd R, every FIFO entry with rd=R is marked invalid, including a result accepted in the same cycle with mc_rd_i=R.
- Invalid head is popped in any cycle without a write, at most one pop per cycle total, in addition to the grant rules above (a pipeline write and an invalid-head pop may occur together).
- Simultaneous push and pop: allowed when not full; count unchanged.
- Starvation: wait counter increments (saturating at 15) each cycle a valid head exists and is not popped; cleared on any pop or when FIFO empty. When counter >= STARVE_LIMIT at an edge and valid head exists and stall_o=0, stall_o=1 for the next cycle only. The counter clears on that drain; stall_o is never high two cycles in a row.

## Timing
- Pipeline WB in cycle N appears on rf_* in cycle N+1.
- Multi-cycle result accepted in cycle N becomes head no earlier than N+1; its rf write is visible N+2 at earliest.
- Forced stall: head waits STARVE_LIMIT unserved cycles; stall_o high the following cycle; head visible on rf_* the cycle after that.
- Full FIFO: mc_ready_o low the same cycle count reaches DEPTH; rises the cycle after the first pop.

## Test plan
- Reset: hold rst_n=0 three cycles with wb_regwrt_i=1, mc_valid_i=1 -> rf_we_o=0, stall_o=0, mc_ready_o=0, fifo_count_o=0.
- Pipeline only: wb_regwrt_i=1, wb_alu_to_reg_i=0, wb_mem_res_i=0xDEADBEEF, wb_rd_i=5 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF.
- Idle drain: push mc_rd_i=7, data=0x1234 with wb_regwrt_i=0 -> two cycles later rf_waddr_o=7, rf_wdata_o=0x1234, fifo_count_o returns to 0.
- Starvation: push one mc result, keep wb_regwrt_i=1 continuously, STARVE_LIMIT=4 -> stall_o high exactly one cycle after 4 blocked cycles, mc result written the next cycle, held pipeline write follows with no loss.
- Squash: push mc_rd_i=3, then pipeline write rd=3 before drain -> only pipeline value reaches register 3; fifo_count_o decrements with no rf write for the squashed entry.
- Full: DEPTH=2, push 3 results while pipeline busy -> mc_ready_o=0 after two accepts; third accepted only after first pop; results written in FIFO order.
